// File: rtl/param_register_file.sv
// Parametrised register file: two combinational read ports, one write port with
// write-through bypass, and a per-register busy scoreboard. Define RF_ZERO_REG_EN to hard-wire register 0 to zero.

module rf_entry #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             set,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            if (we)
                q <= wdata;
            // A new producer issued in the retiring cycle keeps the entry busy.
            if (set)
                busy <= 1'b1;
            else if (we)
                busy <= 1'b0;
        end
    end

endmodule

module param_register_file #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    Rs,
    input  logic [AW-1:0]    Rt,
    input  logic [AW-1:0]    Rd,
    input  logic [WIDTH-1:0] RW,
    input  logic             wr,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    output logic [WIDTH-1:0] Rout1,
    output logic [WIDTH-1:0] Rout2,
    output logic             stall,
    output logic [DEPTH-1:0] busy_vec
);

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy;
    logic                        hit1;
    logic                        hit2;
    logic                        byp1;
    logic                        byp2;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_ent
            if (ZERO_REG && i == 0) begin : g_zero
                assign regs[i] = '0;
                assign busy[i] = 1'b0;
            end else begin : g_reg
                rf_entry #(.WIDTH(WIDTH)) u_ent (
                    .clk   (clk),
                    .rst   (rst),
                    .we    (wr && (Rd == AW'(i))),
                    .wdata (RW),
                    .set   (iss_en && (iss_rd == AW'(i))),
                    .q     (regs[i]),
                    .busy  (busy[i])
                );
            end
        end
    endgenerate

    assign hit1 = wr && (Rd == Rs);
    assign hit2 = wr && (Rd == Rt);
    // The hard-wired zero register never forwards write data.
    assign byp1 = hit1 && !(ZERO_REG && (Rs == '0));
    assign byp2 = hit2 && !(ZERO_REG && (Rt == '0));

    assign Rout1    = byp1 ? RW : regs[Rs];
    assign Rout2    = byp2 ? RW : regs[Rt];
    assign stall    = (busy[Rs] && !hit1) || (busy[Rt] && !hit2);
    assign busy_vec = busy;

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file: directed steps from the test plan,
// then randomized traffic against an array-based reference model.

module tb_param_register_file;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

`ifdef RF_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    Rs, Rt, Rd, iss_rd;
    logic [WIDTH-1:0] RW;
    logic             wr, iss_en;
    logic [WIDTH-1:0] Rout1, Rout2;
    logic             stall;
    logic [DEPTH-1:0] busy_vec;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] m_reg  [DEPTH];
    bit               m_busy [DEPTH];

    param_register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .Rs(Rs), .Rt(Rt), .Rd(Rd), .RW(RW), .wr(wr),
        .iss_en(iss_en), .iss_rd(iss_rd), .Rout1(Rout1), .Rout2(Rout2),
        .stall(stall), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] m_read(input int a);
        if (wr && int'(Rd) == a && !(ZR && a == 0)) return RW;
        return m_reg[a];
    endfunction

    function automatic logic m_stall();
        return (m_busy[Rs] && !(wr && Rd == Rs)) || (m_busy[Rt] && !(wr && Rd == Rt));
    endfunction

    function automatic logic [DEPTH-1:0] m_bvec();
        logic [DEPTH-1:0] v = '0;
        for (int k = 0; k < DEPTH; k++) v[k] = m_busy[k];
        return v;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    task automatic drive(input bit w, input int d, input int data, input bit ie,
                         input int ir, input int s, input int t);
        wr = w; Rd = AW'(d); RW = WIDTH'(data); iss_en = ie; iss_rd = AW'(ir);
        Rs = AW'(s); Rt = AW'(t);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rout1"}, 32'(Rout1), 32'(m_read(int'(Rs))));
        chk({tag, ".rout2"}, 32'(Rout2), 32'(m_read(int'(Rt))));
        chk({tag, ".stall"}, 32'(stall), 32'(m_stall()));
        chk({tag, ".busy"},  32'(busy_vec), 32'(m_bvec()));
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (wr && !(ZR && Rd == 0)) begin
                m_reg[Rd]  = RW;
                m_busy[Rd] = 1'b0;
            end
            if (iss_en && !(ZR && iss_rd == 0)) m_busy[iss_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        m_reset();
        drive(0, 0, 0, 0, 0, 3, 4);
        chk("reset.rout1", 32'(Rout1), 32'h0);
        chk("reset.stall", 32'(stall), 32'h0);
        chk("reset.busy",  32'(busy_vec), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // write then read, full sweep
        drive(1, 3, 16'h1234, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 3, 3);
        chk("wr.rout1", 32'(Rout1), 32'h1234);
        chk("wr.rout2", 32'(Rout2), 32'h1234);
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, 0, 0, 0, 0, k, DEPTH - 1 - k);
            chk("sweep.rout1", 32'(Rout1), (k == 3) ? 32'h1234 : 32'h0);
            check_model("sweep");
        end

        // bypass
        drive(1, 7, 16'h00AA, 0, 0, 0, 0);
        tick();
        drive(1, 7, 16'h5555, 0, 0, 7, 7);
        chk("byp.rout1", 32'(Rout1), 32'h5555);
        chk("byp.rout2", 32'(Rout2), 32'h5555);
        chk("byp.stall", 32'(stall), 32'h0);
        tick();

        // scoreboard set and writeback clear
        drive(0, 0, 0, 1, 9, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 9, 0);
        chk("sb.stall_set", 32'(stall), 32'h1);
        chk("sb.busy9_set", 32'(busy_vec[9]), 32'h1);
        drive(1, 9, 16'h0909, 0, 0, 9, 0);
        chk("sb.stall_wb", 32'(stall), 32'h0);
        chk("sb.rout1_wb", 32'(Rout1), 32'h0909);
        tick();
        drive(0, 0, 0, 0, 0, 9, 0);
        chk("sb.busy9_clr", 32'(busy_vec[9]), 32'h0);
        chk("sb.stall_clr", 32'(stall), 32'h0);

        // simultaneous set and clear
        drive(0, 0, 0, 1, 4, 0, 0);
        tick();
        drive(1, 4, 16'hCAFE, 1, 4, 0, 0);
        tick();
        drive(0, 0, 0, 1, 6, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 4, 6);
        chk("sim.busy4", 32'(busy_vec[4]), 32'h1);
        chk("sim.reg4", 32'(dut.regs[4]), 32'hCAFE);
        chk("sim.stall", 32'(stall), 32'h1);
        drive(1, 6, 16'h0606, 1, 2, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("sim.busy2", 32'(busy_vec[2]), 32'h1);
        chk("sim.busy6", 32'(busy_vec[6]), 32'h0);
        check_model("sim");

        // zero register
        drive(1, 0, 16'hFFFF, 0, 0, 0, 0);
        chk("zero.same", 32'(Rout1), ZR ? 32'h0 : 32'hFFFF);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("zero.next", 32'(Rout1), ZR ? 32'h0 : 32'hFFFF);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("zero.busy0", 32'(busy_vec[0]), ZR ? 32'h0 : 32'h1);
        check_model("zero");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, 16'hFFFF), $urandom_range(0, 2) == 0,
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, DEPTH - 1));
            check_model("rand");
            tick();
        end

        // asynchronous reset mid-run
        drive(1, 5, 16'hBEEF, 1, 11, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 5, 11);
        chk("rst.pre", 32'(Rout1), 32'hBEEF);
        rst = 1'b1;
        m_reset();
        #1;
        chk("rst.rout1", 32'(Rout1), 32'h0);
        chk("rst.busy",  32'(busy_vec), 32'h0);
        chk("rst.stall", 32'(stall), 32'h0);
        drive(1, 2, 16'h0077, 1, 2, 2, 5);
        chk("rst.byp", 32'(Rout1), 32'h0077);
        tick();
        drive(0, 0, 0, 0, 0, 2, 5);
        check_model("rst.ign");
        rst = 1'b0;
        for (int n = 0; n < 100; n++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, 16'hFFFF), $urandom_range(0, 2) == 0,
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, DEPTH - 1));
            check_model("post");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised multi-ported register file with write-through bypass and a per-register busy scoreboard, the next-generation replacement for the 16x16-bit file in the RISC core datapath. It provides two asynchronous read ports and one synchronous write port, all sized by parameter. It tracks registers with an outstanding (issued, not yet written back) result and raises a stall when a read port addresses one. It sits between the decode stage, which issues reads and destinations, and the writeback stage, which drives the write port.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 16, number of registers; power of two, 2..256
- AW, $clog2(DEPTH), register address width
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- Rs  input  AW  read port 1 address
- Rt  input  AW  read port 2 address
- Rd  input  AW  write address
- RW  input  WIDTH  write data
- wr  input  1  write enable; also clears busy[Rd]
- iss_en  input  1  issue strobe; marks iss_rd busy
- iss_rd  input  AW  destination register being issued
- Rout1  output  WIDTH  read data, port 1
- Rout2  output  WIDTH  read data, port 2
- stall  output  1  a read port addresses a busy register that is not being written this cycle
- busy_vec  output  DEPTH  scoreboard state, bit i = register i busy

## Operation
- Storage: DEPTH x WIDTH flops. On a clk edge with wr=1, reg[Rd] <= RW. Exactly one register is updated per write; no latched decode, no stale enables.
- Read ports: combinational. Rout1 = (wr && Rd==Rs) ? RW : reg[Rs]; same for Rout2/Rt. Bypass gives write-first semantics within the cycle.
- Both read ports may address the same register, including the one being written; both return identical data.
- Scoreboard: busy[i] is a flop per register.
  - iss_en=1: busy[iss_rd] <= 1 at the edge.
  - wr=1: busy[Rd] <= 0 at the edge.
  - iss_en and wr to the same register in the same cycle: set wins (new producer overrides retiring one); busy stays 1.
  - iss_en and wr to different registers: both take effect.
  - wr to a non-busy register is legal; busy stays 0.
  - iss_en to an already-busy register is legal; busy stays 1.
- stall = (busy[Rs] && !(wr && Rd==Rs)) || (busy[Rt] && !(wr && Rd==Rt)). Combinational, no dependence on iss_en.
- Address range is exactly 0..DEPTH-1. No out-of-range case exists.

## Timing
- Reset (rst=1, async): all registers 0, all busy bits 0. Effect is immediate, independent of clk. While rst=1: Rout1=Rout2=0 unless a bypass is active, stall=0, busy_vec=0. Writes and issues are ignored.
- Reset deasserting mid-operation: first edge after release behaves normally. In-flight scoreboard entries are lost by design.
- Write latency: 1 edge to storage, 0 cycles via bypass. Read latency: 0 cycles.
- Scoreboard latency: busy is visible on busy_vec and stall in the cycle after the iss_en edge. It clears in the cycle after the wr edge, and the bypass covers the writeback cycle itself.
- No handshake beyond the above. The decode stage must hold the instruction while stall=1.

## Configuration
- RF_ZERO_REG_EN defined: register 0 is hard-wired to zero.
  - Writes to address 0 are discarded, and address 0 is excluded from the bypass, so reads of 0 always return 0.
  - busy[0] is never set and always reads 0.
- RF_ZERO_REG_EN undefined: register 0 is an ordinary register.

## Test plan
- Reset and readback: assert rst mid-run after writing 0xBEEF to reg 5 → Rout1(Rs=5)=0, busy_vec=0 immediately, before any clk edge.
- Write then read: wr, Rd=3, RW=0x1234 → next cycle Rs=3, Rt=3 both give 0x1234. All other registers are unchanged (sweep all DEPTH).
- Bypass: hold reg 7=0x00AA, drive wr, Rd=7, RW=0x5555, Rs=7 in the same cycle → Rout1=0x5555 before the edge, stall=0.
- Scoreboard: iss_en, iss_rd=9 → next cycle Rs=9 gives stall=1, busy_vec[9]=1. Then wr, Rd=9 → stall=0 in that cycle, and busy_vec[9]=0 after the edge.
- Simultaneous set/clear: busy[4]=1, same cycle iss_en with iss_rd=4 and wr with Rd=4 → busy[4] stays 1 and reg 4 takes RW. A further cycle with iss_en=1, iss_rd=2 and wr=1, Rd=6 sets busy[2] and clears busy[6].
- Zero register (RF_ZERO_REG_EN): wr, Rd=0, RW=0xFFFF, Rs=0 → Rout1=0 in the same and next cycle. iss_en, iss_rd=0 → busy_vec[0]=0. Without the macro: Rout1=0xFFFF.
